// File: rtl/gpu_compute_pkg.sv
// Shared compute-cluster definitions: default geometry, accumulator group
// state and small width/lane helpers used by the systolic engine.
package gpu_compute_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 32;

  // Widest value the extend helper handles; callers cast down to their width.
  localparam int MAX_EXT_W  = 128;
  localparam int MAX_EXT_LG = 7;

  // Accumulator group state: OPEN while a K-tile group has partial sums pending.
  typedef enum logic {
    ACC_CLOSED = 1'b0,
    ACC_OPEN   = 1'b1
  } acc_state_e;

  // Extend the low src_w bits of val to full width, sign or zero fill.
  function automatic logic [MAX_EXT_W-1:0] extend_val(
    input logic [MAX_EXT_W-1:0] val,
    input int unsigned          src_w,
    input logic                 is_signed
  );
    logic [MAX_EXT_W-1:0] res;
    logic                 fill;
    fill = is_signed & val[MAX_EXT_LG'(src_w - 1)];
    res  = val;
    for (int unsigned i = 0; i < MAX_EXT_W; i++) begin
      if (i >= src_w) res[MAX_EXT_LG'(i)] = fill;
    end
    return res;
  endfunction

  // LSB position of a lane inside a flattened lane vector.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mvm_pe_row.sv
// One systolic pipeline stage: row ROW of the PE grid. Adds act[ROW]*W[ROW][c]
// to every column partial sum and forwards the activation vector and tags.
module mvm_pe_row
  import gpu_compute_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int ROW        = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             adv,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_row,
  input  logic                             in_valid,
  input  logic                             in_signed,
  input  logic                             in_last,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_act,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  in_psum,
  output logic                             out_valid,
  output logic                             out_signed,
  output logic                             out_last,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_act,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_psum
);

  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int unsigned ACT_LSB = lane_lsb(ROW, DW);

  logic [DW-1:0]     act_lane;
  logic [2*DW-1:0]   act_ext;
  logic [N*AW-1:0]   psum_next;

  assign act_lane = in_act[ACT_LSB +: DW];
  // Operands are widened to 2*DW first so the truncated product is exact
  // for both signed and unsigned interpretation.
  assign act_ext  = {{DW{in_signed & act_lane[DW-1]}}, act_lane};

  for (genvar gi = 0; gi < N; gi++) begin : g_mac
    localparam int unsigned W_LSB = lane_lsb(gi, DW);
    localparam int unsigned A_LSB = lane_lsb(gi, AW);
    logic [DW-1:0]   w_lane;
    logic [2*DW-1:0] w_ext;
    logic [2*DW-1:0] prod;
    logic [AW-1:0]   prod_ext;

    assign w_lane   = w_row[W_LSB +: DW];
    assign w_ext    = {{DW{in_signed & w_lane[DW-1]}}, w_lane};
    assign prod     = act_ext * w_ext;
    assign prod_ext = AW'(extend_val(MAX_EXT_W'(prod), 2 * DW, in_signed));
    assign psum_next[A_LSB +: AW] = in_psum[A_LSB +: AW] + prod_ext;
  end

  // Stage register: loads only when the whole pipeline advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_signed <= 1'b0;
      out_last   <= 1'b0;
      out_act    <= '0;
      out_psum   <= '0;
    end else if (adv) begin
      out_valid  <= in_valid;
      out_signed <= in_signed;
      out_last   <= in_last;
      out_act    <= in_act;
      out_psum   <= psum_next;
    end
  end

endmodule

// File: rtl/systolic_mvm_engine.sv
// Weight-stationary matrix-vector engine: double-buffered weights, N-stage
// systolic pipeline, K-tile output accumulator and back-pressured result.
module systolic_mvm_engine
  import gpu_compute_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  localparam int IDX_W     = $clog2(ARRAY_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             w_wr_en,
  input  logic [IDX_W-1:0]                 w_wr_row,
  input  logic [IDX_W-1:0]                 w_wr_col,
  input  logic [DATA_WIDTH-1:0]            w_wr_data,
  input  logic                             w_swap,
  output logic                             w_swap_ready,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_act,
  input  logic                             in_signed,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_result,
  output logic                             busy
);

  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam logic [IDX_W:0] N_LIMIT = (IDX_W + 1)'(N);

  logic [DW-1:0]   bank_reg [2][N][N];
  logic            active_reg;
  logic            adv;
  logic            accept;
  logic            swap_fire;
  logic            wr_in_range;

  logic [N-1:0]    row_valid;
  logic [N-1:0]    row_signed;
  logic [N-1:0]    row_last;
  logic [N*DW-1:0] row_act  [N];
  logic [N*AW-1:0] row_psum [N];
  logic [N*DW-1:0] w_row    [N];

  acc_state_e      acc_state_reg, acc_state_next;
  logic [N*AW-1:0] acc_reg, acc_next;
  logic [N*AW-1:0] sum_all;
  logic            out_valid_reg, out_valid_next;
  logic [N*AW-1:0] out_result_reg, out_result_next;

  // A stalled result freezes every stage and the accumulator.
  assign adv          = !(out_valid_reg && !out_ready);
  assign in_ready     = adv;
  assign accept       = in_valid && adv;
  // Swapping only with an empty pipeline keeps each vector on one bank.
  assign w_swap_ready = !(|row_valid) && !accept;
  assign swap_fire    = w_swap && w_swap_ready;
  assign wr_in_range  = ({1'b0, w_wr_row} < N_LIMIT) && ({1'b0, w_wr_col} < N_LIMIT);

  // Weight banks: writes go to the shadow bank selected before any swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            bank_reg[b][r][c] <= '0;
      active_reg <= 1'b0;
    end else begin
      if (w_wr_en && wr_in_range) bank_reg[~active_reg][w_wr_row][w_wr_col] <= w_wr_data;
      if (swap_fire) active_reg <= ~active_reg;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    logic            v_in;
    logic            s_in;
    logic            l_in;
    logic [N*DW-1:0] a_in;
    logic [N*AW-1:0] p_in;

    for (genvar gj = 0; gj < N; gj++) begin : g_wsel
      assign w_row[gi][gj*DW +: DW] = bank_reg[active_reg][gi][gj];
    end

    if (gi == 0) begin : g_head
      assign v_in = accept;
      assign s_in = in_signed;
      assign l_in = in_last;
      assign a_in = in_act;
      assign p_in = '0;
    end else begin : g_link
      assign v_in = row_valid[gi-1];
      assign s_in = row_signed[gi-1];
      assign l_in = row_last[gi-1];
      assign a_in = row_act[gi-1];
      assign p_in = row_psum[gi-1];
    end

    mvm_pe_row #(
      .ARRAY_SIZE(N),
      .DATA_WIDTH(DW),
      .ACC_WIDTH (AW),
      .ROW       (gi)
    ) u_row (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .w_row     (w_row[gi]),
      .in_valid  (v_in),
      .in_signed (s_in),
      .in_last   (l_in),
      .in_act    (a_in),
      .in_psum   (p_in),
      .out_valid (row_valid[gi]),
      .out_signed(row_signed[gi]),
      .out_last  (row_last[gi]),
      .out_act   (row_act[gi]),
      .out_psum  (row_psum[gi])
    );

    assign sum_all[gi*AW +: AW] = acc_reg[gi*AW +: AW] + row_psum[N-1][gi*AW +: AW];
  end

  // Accumulator group FSM and output register next-state.
  always_comb begin
    acc_state_next  = acc_state_reg;
    acc_next        = acc_reg;
    out_valid_next  = out_valid_reg;
    out_result_next = out_result_reg;
    if (adv) begin
      out_valid_next = 1'b0;
      if (row_valid[N-1]) begin
        if (row_last[N-1]) begin
          out_valid_next  = 1'b1;
          out_result_next = sum_all;
          acc_next        = '0;
          acc_state_next  = ACC_CLOSED;
        end else begin
          acc_next       = sum_all;
          acc_state_next = ACC_OPEN;
        end
      end
    end
  end

  // Accumulator and output state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_state_reg  <= ACC_CLOSED;
      acc_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
    end else begin
      acc_state_reg  <= acc_state_next;
      acc_reg        <= acc_next;
      out_valid_reg  <= out_valid_next;
      out_result_reg <= out_result_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign busy       = (|row_valid) || (acc_state_reg == ACC_OPEN) || out_valid_reg;

endmodule

// File: tb/tb_systolic_mvm_engine.sv
// Directed bench for systolic_mvm_engine with an expected-result scoreboard.
module tb_systolic_mvm_engine;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int AW    = 32;
  localparam int IDX_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_row;
  logic [IDX_W-1:0]  w_wr_col;
  logic [DW-1:0]     w_wr_data;
  logic              w_swap;
  logic              w_swap_ready;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   in_act;
  logic              in_signed;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [N*AW-1:0]   out_result;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_out = 0;
  logic [N*AW-1:0] sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_mvm_engine #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .w_wr_en     (w_wr_en),
    .w_wr_row    (w_wr_row),
    .w_wr_col    (w_wr_col),
    .w_wr_data   (w_wr_data),
    .w_swap      (w_swap),
    .w_swap_ready(w_swap_ready),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_act      (in_act),
    .in_signed   (in_signed),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [N*AW-1:0] obs, input logic [N*AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result monitor: every output handshake pops one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      n_cmp++;
      assert (sb_q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_underflow: observed output %h expected no output", out_result);
      end
      if (sb_q.size() > 0) chk("result", out_result, sb_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*DW-1:0] av(input int a0, input int a1, input int a2, input int a3);
    return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  function automatic logic [N*AW-1:0] rv(input int r0, input int r1, input int r2, input int r3);
    return {AW'(r3), AW'(r2), AW'(r1), AW'(r0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int r, input int c, input int d);
    w_wr_en   = 1'b1;
    w_wr_row  = IDX_W'(r);
    w_wr_col  = IDX_W'(c);
    w_wr_data = DW'(d);
    tick();
    w_wr_en   = 1'b0;
  endtask

  task automatic send_vec(input logic [N*DW-1:0] act, input logic sgn, input logic lst,
                          input logic push, input logic [N*AW-1:0] exp, output int acc_cyc);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    in_act    = act;
    in_signed = sgn;
    in_last   = lst;
    if (push) sb_q.push_back(exp);
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    acc_cyc = cyc;
    chk("in_accept", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_swap(output int ready_cyc, output logic first_ready);
    int guard;
    guard  = 0;
    w_swap = 1'b1;
    @(negedge clk);
    first_ready = w_swap_ready;
    while (!w_swap_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ready_cyc = cyc;
    chk("swap_ready", w_swap_ready, 1'b1);
    tick();
    w_swap = 1'b0;
  endtask

  task automatic wait_out(output int oc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    oc = cyc;
    chk("out_valid_seen", out_valid, 1'b1);
    tick();
  endtask

  initial begin
    int   ac, ac2, oc, rc, n0;
    logic fr;
    rst = 1'b1; w_wr_en = 1'b0; w_wr_row = '0; w_wr_col = '0; w_wr_data = '0;
    w_swap = 1'b0; in_valid = 1'b0; in_act = '0; in_signed = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state on the first cycle after reset.
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_swap_ready", w_swap_ready, 1'b1);
    chk("rst_out_result", out_result, '0);
    tick();

    // Diagonal weights, single beat, latency N+1.
    for (int r = 0; r < N; r++) wr_w(r, r, r + 1);
    do_swap(rc, fr);
    send_vec(av(10, 20, 30, 40), 1'b0, 1'b1, 1'b1, rv(10, 40, 90, 160), ac);
    wait_out(oc);
    chk("diag_latency", oc - ac, 5);
    repeat (3) tick();

    // K-tile group spanning a bank swap.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wr_w(r, c, 4 * r + c + 1);
    do_swap(rc, fr);
    send_vec(av(1, 1, 1, 1), 1'b0, 1'b0, 1'b0, '0, ac);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wr_w(r, c, 1);
    chk("ktile_no_out", out_valid, 1'b0);
    chk("ktile_group_open", busy, 1'b1);
    do_swap(rc, fr);
    send_vec(av(1, 2, 3, 4), 1'b0, 1'b1, 1'b1, rv(38, 42, 46, 50), ac);
    repeat (8) tick();
    chk("ktile_idle", busy, 1'b0);

    // Signed versus unsigned interpretation per vector.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wr_w(r, c, (r == 0 && c == 0) ? 32'h0000FFFE : 0);
    do_swap(rc, fr);
    send_vec(av(3, 0, 0, 0), 1'b1, 1'b1, 1'b1, rv(-6, 0, 0, 0), ac);
    send_vec(av(3, 0, 0, 0), 1'b0, 1'b1, 1'b1, rv(196602, 0, 0, 0), ac);
    send_vec(av(65535, 0, 0, 0), 1'b1, 1'b1, 1'b1, rv(2, 0, 0, 0), ac);
    send_vec(av(65535, 0, 0, 0), 1'b0, 1'b1, 1'b1, rv(32'hFFFD0002, 0, 0, 0), ac);
    repeat (8) tick();

    // Back-pressure with identity weights.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wr_w(r, c, (r == c) ? 1 : 0);
    do_swap(rc, fr);
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      send_vec(av(k, 2 * k, 3 * k, 4 * k), 1'b0, 1'b1, 1'b1, rv(k, 2 * k, 3 * k, 4 * k), ac);
    wait_out(oc);
    n0 = n_out;
    repeat (3) tick();
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_out_held", out_valid, 1'b1);
    chk("bp_busy", busy, 1'b1);
    out_ready = 1'b1;
    repeat (10) tick();
    chk("bp_out_count", n_out - n0, 4);

    // Swap held off while vectors are in flight; in-flight vectors use old bank.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wr_w(r, c, (r == c) ? 2 : 0);
    send_vec(av(5, 6, 7, 8), 1'b0, 1'b1, 1'b1, rv(5, 6, 7, 8), ac);
    send_vec(av(1, 1, 1, 1), 1'b0, 1'b1, 1'b1, rv(1, 1, 1, 1), ac2);
    do_swap(rc, fr);
    chk("gate_ready_low", fr, 1'b0);
    chk("gate_ready_cycle", rc - ac2, 5);
    send_vec(av(1, 2, 3, 4), 1'b0, 1'b1, 1'b1, rv(2, 4, 6, 8), ac);
    repeat (8) tick();

    // Reset with an open group and three vectors in flight.
    send_vec(av(1, 1, 1, 1), 1'b0, 1'b0, 1'b0, '0, ac);
    repeat (6) tick();
    chk("mid_group_open", busy, 1'b1);
    for (int k = 0; k < 3; k++) send_vec(av(3, 3, 3, 3), 1'b0, 1'b0, 1'b0, '0, ac);
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    send_vec(av(7, 7, 7, 7), 1'b0, 1'b1, 1'b1, rv(0, 0, 0, 0), ac);
    repeat (8) tick();

    chk("sb_empty", sb_q.size(), 0);
    chk("total_outputs", n_out, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
